// File: rtl/xgmii_pkg.sv
// Shared XGMII constants and arbiter state encoding, used by the generators,
// the transmit arbiter and the MAC-side checker.
package xgmii_pkg;

  localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  XGMII_IDLE_C = 8'hff;
  localparam logic [63:0] XGMII_ERR_D  = 64'hfefefefefefefefe;
  localparam logic [7:0]  XGMII_TERM   = 8'hfd;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_IFG
  } arb_state_e;

  // A zero gap setting still yields one IFG cycle.
  function automatic logic [7:0] gap_len(input logic [7:0] ifg);
    return (ifg == 8'd0) ? 8'd1 : ifg;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  // On a tie the port that did not send last wins.
  assign winner = (&req) ? ~last_owner : req[1];

endmodule

// File: rtl/xgmii_tx_arb.sv
// Frame-granular two-port XGMII transmit arbiter with inter-frame gap,
// runaway-frame watchdog and per-port completed-frame counters.
module xgmii_tx_arb
  import xgmii_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  ifg,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic [63:0] d0,
  input  logic [63:0] d1,
  input  logic [7:0]  c0,
  input  logic [7:0]  c1,
  input  logic        last0,
  input  logic        last1,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        abort,
  output logic [31:0] tx_frames0,
  output logic [31:0] tx_frames1
);

  localparam int unsigned WcntW = (MAX_WORDS > 2) ? $clog2(MAX_WORDS) : 1;
  localparam logic [WcntW-1:0] WcntLast = WcntW'(MAX_WORDS - 1);

  arb_state_e       state_q;
  logic             owner_q;
  logic             last_owner_q;
  logic [WcntW-1:0] wcnt_q;
  logic [7:0]       gcnt_q;

  logic        pick_valid;
  logic        pick_winner;
  logic [63:0] own_d;
  logic [7:0]  own_c;
  logic        own_last;

  rr_pick2 u_pick (
    .req       ({req1, req0}),
    .last_owner(last_owner_q),
    .valid     (pick_valid),
    .winner    (pick_winner)
  );

  assign own_d    = owner_q ? d1 : d0;
  assign own_c    = owner_q ? c1 : c0;
  assign own_last = owner_q ? last1 : last0;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wcnt_q       <= '0;
      gcnt_q       <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      xgmii_txd    <= XGMII_IDLE_D;
      xgmii_txc    <= XGMII_IDLE_C;
      abort        <= 1'b0;
      tx_frames0   <= '0;
      tx_frames1   <= '0;
    end else begin
      abort <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          xgmii_txd <= XGMII_IDLE_D;
          xgmii_txc <= XGMII_IDLE_C;
          if (pick_valid) begin
            gnt0         <= ~pick_winner;
            gnt1         <= pick_winner;
            owner_q      <= pick_winner;
            last_owner_q <= pick_winner;
            wcnt_q       <= '0;
            state_q      <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          xgmii_txd <= own_d;
          xgmii_txc <= own_c;
          wcnt_q    <= wcnt_q + WcntW'(1);
          // A terminate on the final legal word takes priority over the watchdog.
          if (own_last) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            gcnt_q  <= gap_len(ifg);
            state_q <= ARB_IFG;
            if (owner_q) tx_frames1 <= tx_frames1 + 32'd1;
            else         tx_frames0 <= tx_frames0 + 32'd1;
          end else if (wcnt_q == WcntLast) begin
            xgmii_txd <= XGMII_ERR_D;
            xgmii_txc <= XGMII_IDLE_C;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            abort     <= 1'b1;
            gcnt_q    <= gap_len(ifg);
            state_q   <= ARB_IFG;
          end
        end
        ARB_IFG: begin
          xgmii_txd <= XGMII_IDLE_D;
          xgmii_txc <= XGMII_IDLE_C;
          gcnt_q    <= gcnt_q - 8'd1;
          if (gcnt_q == 8'd1) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
